// File: rtl/mult_drv_pkg.sv
// Shared types and default parameters for the double_multiplier stb/ack driver.
package mult_drv_pkg;

    localparam int DEF_WIDTH   = 64;    // IEEE-754 double
    localparam int DEF_LAT_W   = 16;    // latency counter width
    localparam int DEF_TIMEOUT = 1023;  // cycles before timeout_err sets

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SEND_A   = 3'd1,
        S_SEND_B   = 3'd2,
        S_WAIT_Z   = 3'd3,
        S_HOLD_RES = 3'd4
    } drv_state_t;

    // States in which an operation is in flight and the latency counter runs.
    function automatic logic is_active(input drv_state_t s);
        return (s == S_SEND_A) || (s == S_SEND_B) || (s == S_WAIT_Z);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear. The output is the value the
// counter takes at the coming edge, so a consumer can capture the count that
// includes the current cycle without waiting an extra clock.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clear,
    input  logic         i_enable,
    output logic [W-1:0] o_count_next
);

    logic [W-1:0] r_count;
    logic [W-1:0] w_count_next;

    // Next-count selection: clear wins, otherwise count up and stick at all-ones.
    always_comb begin
        w_count_next = r_count;
        if (i_clear)
            w_count_next = '0;
        else if (i_enable && (r_count != {W{1'b1}}))
            w_count_next = r_count + 1'b1;
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_count <= '0;
        else
            r_count <= w_count_next;  // NOTE: sequential state always uses <=, so every flop samples pre-edge values.
    end

    assign o_count_next = w_count_next;

endmodule

// File: rtl/mult_stb_driver.sv
// Initiator for the double_multiplier stb/ack protocol: takes an operand pair
// on valid/ready, presents A then B, collects the product and returns it on a
// valid/ready result port together with the operation latency.
module mult_stb_driver
    import mult_drv_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int LAT_W   = DEF_LAT_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    // operand port
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_valid,
    output logic             op_ready,
    // A channel
    output logic [WIDTH-1:0] input_a,
    output logic             input_a_stb,
    input  logic             input_a_ack,
    // B channel
    output logic [WIDTH-1:0] input_b,
    output logic             input_b_stb,
    input  logic             input_b_ack,
    // product channel
    input  logic [WIDTH-1:0] output_z,
    input  logic             output_z_stb,
    output logic             output_z_ack,
    // result port
    output logic [WIDTH-1:0] res,
    output logic             res_valid,
    input  logic             res_ready,
    // status
    output logic [LAT_W-1:0] lat_cycles,
    output logic             timeout_err,
    output logic             busy
);

    drv_state_t       r_state;
    logic [WIDTH-1:0] r_input_a;
    logic [WIDTH-1:0] r_input_b;
    logic             r_a_stb;
    logic             r_b_stb;
    logic             r_z_ack;
    logic [WIDTH-1:0] r_res;
    logic             r_res_valid;
    logic [LAT_W-1:0] r_lat;
    logic             r_timeout;

    logic             w_active;
    logic             w_accept;
    logic [LAT_W-1:0] w_cnt_next;

    assign w_active = is_active(r_state);
    assign w_accept = (r_state == S_IDLE) && op_valid;

    // Latency count: cleared on acceptance, runs only while an operation is in flight.
    sat_counter #(.W(LAT_W)) u_lat_cnt (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (w_accept),
        .i_enable     (w_active),
        .o_count_next (w_cnt_next)
    );

    // Protocol FSM and datapath registers; every handshake output is a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: async reset clears every register here, so the outputs reach reset values without a clock.
            r_state     <= S_IDLE;
            r_input_a   <= '0;
            r_input_b   <= '0;
            r_a_stb     <= 1'b0;
            r_b_stb     <= 1'b0;
            r_z_ack     <= 1'b0;
            r_res       <= '0;
            r_res_valid <= 1'b0;
            r_lat       <= '0;
            r_timeout   <= 1'b0;
        end else begin
            // Sticky flag; the operation itself keeps running to completion.
            if (w_active && (w_cnt_next == LAT_W'(TIMEOUT)))
                r_timeout <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_input_a <= op_a;
                        r_input_b <= op_b;
                        r_a_stb   <= 1'b1;
                        r_state   <= S_SEND_A;
                    end
                end
                S_SEND_A: begin
                    if (r_a_stb && input_a_ack) begin
                        r_a_stb <= 1'b0;
                        r_b_stb <= 1'b1;
                        r_state <= S_SEND_B;
                    end
                end
                S_SEND_B: begin
                    if (r_b_stb && input_b_ack) begin
                        r_b_stb <= 1'b0;
                        r_z_ack <= 1'b1;
                        r_state <= S_WAIT_Z;
                    end
                end
                S_WAIT_Z: begin
                    if (output_z_stb && r_z_ack) begin
                        r_res       <= output_z;
                        r_lat       <= w_cnt_next;
                        r_z_ack     <= 1'b0;
                        r_res_valid <= 1'b1;
                        r_state     <= S_HOLD_RES;
                    end
                end
                S_HOLD_RES: begin
                    if (r_res_valid && res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_a_stb     <= 1'b0;
                    r_b_stb     <= 1'b0;
                    r_z_ack     <= 1'b0;
                    r_res_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign op_ready     = (r_state == S_IDLE);
    assign busy         = (r_state != S_IDLE);
    assign input_a      = r_input_a;
    assign input_b      = r_input_b;
    assign input_a_stb  = r_a_stb;
    assign input_b_stb  = r_b_stb;
    assign output_z_ack = r_z_ack;
    assign res          = r_res;
    assign res_valid    = r_res_valid;
    assign lat_cycles   = r_lat;
    assign timeout_err  = r_timeout;

endmodule
